// File: rtl/eq_coeff_loader.sv
// rtl/eq_coeff_loader.sv - serialises packed host coefficient words into per-bin equalizer writes
module eq_coeff_loader #(
  parameter int SAMPLES    = 2048,
  parameter int COEFF_BITS = 8,
  parameter int WORD_BITS  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       mirror_en,
  input  logic [WORD_BITS-1:0]       word_in,
  input  logic                       word_valid,
  output logic                       word_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       coeff_wr_en,
  output logic [$clog2(SAMPLES)-1:0] coeff_index,
  output logic [COEFF_BITS-1:0]      coeff_in
);

  localparam int LANES = WORD_BITS / COEFF_BITS;
  localparam int KW    = $clog2(SAMPLES);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [KW:0]   NB_FULL   = (KW+1)'(SAMPLES);
  localparam logic [KW:0]   NB_MIR    = (KW+1)'(SAMPLES / 2 + 1);
  localparam logic [KW:0]   HALF      = (KW+1)'(SAMPLES / 2);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_WRITE_MIR = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]           state;
  logic [KW:0]          k;
  logic [LW-1:0]        lane;
  logic [WORD_BITS-1:0] word_q;
  logic                 mir_q;

  logic [KW:0] nb;
  logic        last_bin;
  logic        mir_pair;

  assign nb       = mir_q ? NB_MIR : NB_FULL;
  assign last_bin = ((k + 1'b1) == nb);
  // DC and Nyquist bins are their own conjugate partners, so they are written once.
  assign mir_pair = mir_q && (k != '0) && (k != HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      k      <= '0;
      lane   <= '0;
      word_q <= '0;
      mir_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k     <= '0;
            lane  <= '0;
            mir_q <= mirror_en;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (word_valid) begin
            word_q <= word_in;
            lane   <= '0;
            state  <= S_WRITE;
          end
        end
        S_WRITE, S_WRITE_MIR: begin
          if (state == S_WRITE && mir_pair) begin
            state <= S_WRITE_MIR;
          end else begin
            k <= k + 1'b1;
            if (last_bin) begin
              state <= S_DONE;
            end else if (lane == LANE_LAST) begin
              state <= S_FETCH;
            end else begin
              lane  <= lane + 1'b1;
              state <= S_WRITE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign word_ready  = (state == S_FETCH);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign coeff_wr_en = (state == S_WRITE) || (state == S_WRITE_MIR);

  always_comb begin
    coeff_index = '0;
    if (state == S_WRITE)
      coeff_index = k[KW-1:0];
    else if (state == S_WRITE_MIR)
      coeff_index = KW'(NB_FULL - k);
  end

  assign coeff_in = coeff_wr_en ? word_q[lane*COEFF_BITS +: COEFF_BITS] : '0;

endmodule

// File: tb/tb_eq_coeff_loader.sv
// tb/tb_eq_coeff_loader.sv - scoreboard bench for eq_coeff_loader at SAMPLES=16
module tb_eq_coeff_loader;

  localparam int SAMPLES = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mirror_en;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic        done;
  logic        coeff_wr_en;
  logic [3:0]  coeff_index;
  logic [7:0]  coeff_in;

  eq_coeff_loader #(.SAMPLES(SAMPLES), .COEFF_BITS(8), .WORD_BITS(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mirror_en   (mirror_en),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .busy        (busy),
    .done        (done),
    .coeff_wr_en (coeff_wr_en),
    .coeff_index (coeff_index),
    .coeff_in    (coeff_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] sb[$];
  logic [11:0] exp_e;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  bit          prev_last = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_after_last", 32'(prev_last), 1);
    end
    prev_last = 0;
    if (coeff_wr_en) begin
      wr_cnt++;
      check("wr_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_e = sb.pop_front();
        check("wr_index", 32'(coeff_index), 32'(exp_e[11:8]));
        check("wr_value", 32'(coeff_in), 32'(exp_e[7:0]));
        prev_last = (sb.size() == 0);
      end
    end
  end

  function automatic logic [31:0] word_of(input logic [7:0] base, input int j);
    logic [31:0] w;
    for (int l = 0; l < 4; l++) w[8*l +: 8] = 8'(base + 4*j + l);
    return w;
  endfunction

  task automatic push_expected(input bit mir, input logic [7:0] base);
    if (!mir) begin
      for (int i = 0; i < SAMPLES; i++) sb.push_back({4'(i), 8'(base + i)});
    end else begin
      sb.push_back({4'd0, base});
      for (int i = 1; i < SAMPLES/2; i++) begin
        sb.push_back({4'(i), 8'(base + i)});
        sb.push_back({4'(SAMPLES - i), 8'(base + i)});
      end
      sb.push_back({4'(SAMPLES/2), 8'(base + SAMPLES/2)});
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    word_in    = w;
    word_valid = 1'b1;
    n = 0;
    while (!word_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hs_ready", 32'(word_ready), 1);
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 32'(word_ready), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_wr_en"}, 32'(coeff_wr_en), 0);
    check({tag, "_index"}, 32'(coeff_index), 0);
    check({tag, "_coeff"}, 32'(coeff_in), 0);
  endtask

  task automatic run_load(input bit mir, input logic [7:0] base, input int stall_word, input bit poke);
    int nw;
    nw = mir ? 3 : 4;
    done_cnt = 0;
    push_expected(mir, base);
    start     = 1'b1;
    mirror_en = mir;
    @(negedge clk);
    start     = 1'b0;
    mirror_en = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_ready", 32'(word_ready), 1);
    for (int j = 0; j < nw; j++) begin
      if (j == stall_word) begin
        for (int n = 0; n < 50 && !word_ready; n++) @(negedge clk);
        repeat (7) begin
          check("stall_ready", 32'(word_ready), 1);
          check("stall_no_wr", 32'(coeff_wr_en), 0);
          @(negedge clk);
        end
      end
      send_word(word_of(base, j));
      if (poke && j == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_done();
    @(negedge clk);
    check("end_busy", 32'(busy), 0);
    check("end_done_pulse", 32'(done), 0);
    check("end_done_cnt", done_cnt, 1);
    check("end_sb_empty", sb.size(), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    mirror_en  = 1'b0;
    word_in    = '0;
    word_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    run_load(1'b0, 8'h00, -1, 1'b0);
    run_load(1'b1, 8'h20, -1, 1'b0);
    run_load(1'b0, 8'h00, 1, 1'b0);
    run_load(1'b0, 8'h30, -1, 1'b1);

    // Asynchronous reset after the 6th strobe abandons the load.
    done_cnt = 0;
    wr_cnt   = 0;
    push_expected(1'b0, 8'h60);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(word_of(8'h60, 0));
    send_word(word_of(8'h60, 1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    check("rst_wr_cnt", wr_cnt, 6);
    sb.delete();
    word_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_done_cnt", done_cnt, 0);
    run_load(1'b0, 8'h70, -1, 1'b0);

    // Back-to-back loads with start held high.
    done_cnt = 0;
    push_expected(1'b0, 8'h40);
    start = 1'b1;
    @(negedge clk);
    check("b2b_first_ready", 32'(word_ready), 1);
    for (int j = 0; j < 4; j++) send_word(word_of(8'h40, j));
    wait_done();
    @(negedge clk);
    check("b2b_idle_busy", 32'(busy), 0);
    check("b2b_idle_ready", 32'(word_ready), 0);
    push_expected(1'b0, 8'h50);
    @(negedge clk);
    check("b2b_fetch", 32'(word_ready), 1);
    start = 1'b0;
    for (int j = 0; j < 4; j++) send_word(word_of(8'h50, j));
    wait_done();
    @(negedge clk);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_sb_empty", sb.size(), 0);
    check("b2b_end_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
